// File: rtl/riscv_if.sv
// Instruction-fetch stage of the 5-stage RISC-V pipeline.
// Owns the PC and issues pipelined word reads over a req/gnt/rvalid interface.
// Responses are buffered in a small in-order FIFO and fed to the IF/ID register.
// A credit rule guarantees a free FIFO slot for every in-flight response.
// Redirects flush the buffer and discard the responses still in flight.
module riscv_if #(
   parameter int unsigned          WORD_SIZE  = 32,
   parameter logic [WORD_SIZE-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned          FIFO_DEPTH = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   output logic                 imem_req_o,
   output logic [WORD_SIZE-1:0] imem_addr_o,
   input  logic                 imem_gnt_i,
   input  logic                 imem_rvalid_i,
   input  logic [WORD_SIZE-1:0] imem_rdata_i,
   input  logic                 stall_i,
   input  logic                 branch_taken_i,
   input  logic [WORD_SIZE-1:0] branch_target_i,
   output logic [WORD_SIZE-1:0] PC_ID_o,
   output logic [WORD_SIZE-1:0] instr_ID_o,
   output logic                 valid_ID_o
);

   localparam int unsigned          PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned          CNT_W   = PTR_W + 1;
   localparam int unsigned          SUM_W   = CNT_W + 1;
   localparam logic [WORD_SIZE-1:0] NOP     = WORD_SIZE'(32'h0000_0013);
   localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(32'd4);

   // Fetch-side state: next fetch address and PC of the next live response
   logic [WORD_SIZE-1:0] pc_r;
   logic [WORD_SIZE-1:0] rsp_pc_r;
   // All in-flight requests (live and stale), and how many of them are stale
   logic [CNT_W-1:0]     out_cnt_r;
   logic [CNT_W-1:0]     disc_cnt_r;
   // Instruction buffer
   logic [CNT_W-1:0]     fifo_cnt_r;
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [WORD_SIZE-1:0] fifo_pc_r    [FIFO_DEPTH];
   logic [WORD_SIZE-1:0] fifo_instr_r [FIFO_DEPTH];
   // IF/ID pipeline register
   logic [WORD_SIZE-1:0] id_pc_r;
   logic [WORD_SIZE-1:0] id_instr_r;
   logic                 id_valid_r;

   logic                 pop_s;
   logic                 push_s;
   logic                 drop_s;
   logic                 req_s;
   logic                 grant_s;
   logic [SUM_W-1:0]     credit_s;
   logic [WORD_SIZE-1:0] target_s;
   logic                 unused_s;

   // Low target bits are ignored: redirects always land on a word boundary
   assign unused_s = ^branch_target_i[1:0];

   // Per-cycle decisions: pop, credit-limited request, accept or drop of a response
   always_comb begin
      target_s = {branch_target_i[WORD_SIZE-1:2], 2'b00};
      pop_s    = (fifo_cnt_r != {CNT_W{1'b0}}) && !stall_i && !branch_taken_i;
      credit_s = SUM_W'(out_cnt_r) + SUM_W'(fifo_cnt_r) - SUM_W'(pop_s);
      req_s    = rst_ni && !branch_taken_i && (credit_s < SUM_W'(FIFO_DEPTH));
      grant_s  = req_s && imem_gnt_i;
      push_s   = imem_rvalid_i && !branch_taken_i && (disc_cnt_r == {CNT_W{1'b0}});
      drop_s   = imem_rvalid_i && !branch_taken_i && (disc_cnt_r != {CNT_W{1'b0}});
   end

   // Fetch PC and response PC tracking; both restart at the target on redirect
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_r     <= RESET_PC;
         rsp_pc_r <= RESET_PC;
      end else if (branch_taken_i) begin
         pc_r     <= target_s;
         rsp_pc_r <= target_s;
      end else begin
         pc_r     <= grant_s ? (pc_r + PC_STEP) : pc_r;
         rsp_pc_r <= push_s ? (rsp_pc_r + PC_STEP) : rsp_pc_r;
      end
   end

   // In-flight and discard counters; on redirect everything still pending becomes stale
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_cnt_r  <= {CNT_W{1'b0}};
         disc_cnt_r <= {CNT_W{1'b0}};
      end else if (branch_taken_i) begin
         out_cnt_r  <= out_cnt_r - CNT_W'(imem_rvalid_i);
         disc_cnt_r <= out_cnt_r - CNT_W'(imem_rvalid_i);
      end else begin
         out_cnt_r  <= out_cnt_r + CNT_W'(grant_s) - CNT_W'(imem_rvalid_i);
         disc_cnt_r <= disc_cnt_r - CNT_W'(drop_s);
      end
   end

   // Instruction buffer: in-order push of live responses, pop into IF/ID, flush on redirect
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_cnt_r <= {CNT_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_r[i]    <= {WORD_SIZE{1'b0}};
            fifo_instr_r[i] <= NOP;
         end
      end else if (branch_taken_i) begin
         fifo_cnt_r <= {CNT_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
      end else begin
         if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= rsp_pc_r;
            fifo_instr_r[wr_ptr_r] <= imem_rdata_i;
            wr_ptr_r               <= wr_ptr_r + PTR_W'(1'b1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         rd_ptr_r   <= pop_s ? (rd_ptr_r + PTR_W'(1'b1)) : rd_ptr_r;
         fifo_cnt_r <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // IF/ID register: redirect bubble, then stall hold, then load, else bubble
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_pc_r    <= {WORD_SIZE{1'b0}};
         id_instr_r <= NOP;
         id_valid_r <= 1'b0;
      end else if (branch_taken_i) begin
         id_instr_r <= NOP;
         id_valid_r <= 1'b0;
      end else if (stall_i) begin
         id_pc_r    <= id_pc_r;
         id_instr_r <= id_instr_r;
         id_valid_r <= id_valid_r;
      end else if (pop_s) begin
         id_pc_r    <= fifo_pc_r[rd_ptr_r];
         id_instr_r <= fifo_instr_r[rd_ptr_r];
         id_valid_r <= 1'b1;
      end else begin
         id_instr_r <= NOP;
         id_valid_r <= 1'b0;
      end
   end

   assign imem_req_o  = req_s;
   assign imem_addr_o = pc_r;
   assign PC_ID_o     = id_pc_r;
   assign instr_ID_o  = id_instr_r;
   assign valid_ID_o  = id_valid_r;

endmodule

// File: tb/tb_riscv_if.sv
// Testbench for riscv_if: randomized memory/stall/redirect stimulus compared every
// cycle against a queue-based model of the fetch stage, plus directed timing checks.
module tb_riscv_if;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch;
   logic [31:0] branch_target;
   logic [31:0] pc_id;
   logic [31:0] instr_id;
   logic        valid_id;

   always #5 clk = ~clk;

   riscv_if #(.WORD_SIZE(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .imem_req_o     (imem_req),
      .imem_addr_o    (imem_addr),
      .imem_gnt_i     (imem_gnt),
      .imem_rvalid_i  (imem_rvalid),
      .imem_rdata_i   (imem_rdata),
      .stall_i        (stall),
      .branch_taken_i (branch),
      .branch_target_i(branch_target),
      .PC_ID_o        (pc_id),
      .instr_ID_o     (instr_id),
      .valid_ID_o     (valid_id)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory content is address-derived; key changes only while reset is held
   logic [31:0] data_key;

   // What happened in the last cycle, recorded just before its active edge
   logic        cr_rst = 1'b1;
   logic        cr_stall = 1'b0;
   logic        cr_branch = 1'b0;
   logic        cr_req = 1'b0;
   logic        cr_gnt = 1'b0;
   logic        cr_rvalid = 1'b0;
   logic [31:0] cr_target = 32'h0;
   logic [31:0] cr_addr = 32'h0;

   // Bench memory: in-order responses with per-request latency
   typedef struct { logic [31:0] addr; int due; } mem_t;
   mem_t mq[$];
   int   cyc;
   int   gnt_pct;
   int   lat_min;
   int   lat_max;

   task automatic drive(input logic st, input logic br, input logic [31:0] tgt);
      mem_t h;
      stall         = st;
      branch        = br;
      branch_target = tgt;
      imem_gnt      = (int'($urandom_range(99)) < gnt_pct);
      imem_rvalid   = 1'b0;
      imem_rdata    = $urandom;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         h           = mq.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = h.addr ^ data_key;
      end
      #1;
      cr_rst    = !rst_ni;
      cr_stall  = st;
      cr_branch = br;
      cr_target = tgt;
      cr_req    = imem_req;
      cr_gnt    = imem_gnt;
      cr_addr   = imem_addr;
      cr_rvalid = imem_rvalid;
      if (imem_req && imem_gnt)
         mq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 32'h0);
      end
   endtask

   // Reference model: in-flight queue with stale marks, buffered-instruction queue,
   // next fetch address and the expected IF/ID contents.
   typedef struct { logic [31:0] addr; logic stale; } fl_t;
   fl_t         infl[$];
   logic [31:0] avail[$];
   logic [31:0] m_fetch;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic        m_valid;

   // Compare process: advance the model by the recorded cycle, then check the DUT
   always @(negedge clk) begin : compare
      fl_t         e;
      logic [31:0] head;
      logic        pop;
      logic        exp_req;
      if (cr_rst) begin
         infl.delete();
         avail.delete();
         m_fetch = RESET_PC;
         m_pc    = 32'h0;
         m_instr = NOP;
         m_valid = 1'b0;
      end else begin
         pop     = (avail.size() > 0) && !cr_stall && !cr_branch;
         exp_req = !cr_branch && ((infl.size() + avail.size() - int'(pop)) < int'(DEPTH));
         chk("imem_req", 32'(cr_req), 32'(exp_req));
         if (cr_req)
            chk("imem_addr", cr_addr, m_fetch);
         head = 32'h0;
         if (pop)
            head = avail.pop_front();
         if (cr_rvalid && infl.size() > 0) begin
            e = infl.pop_front();
            if (!cr_branch && !e.stale)
               avail.push_back(e.addr);
         end
         if (cr_branch) begin
            foreach (infl[i]) infl[i].stale = 1'b1;
            avail.delete();
            m_fetch = {cr_target[31:2], 2'b00};
         end else if (cr_req && cr_gnt) begin
            infl.push_back('{addr: m_fetch, stale: 1'b0});
            m_fetch = m_fetch + 32'd4;
         end
         chk("in_flight_le_depth", 32'(infl.size() <= int'(DEPTH)), 32'd1);
         if (cr_branch) begin
            m_instr = NOP;
            m_valid = 1'b0;
         end else if (cr_stall) begin
            m_valid = m_valid;
         end else if (pop) begin
            m_pc    = head;
            m_instr = head ^ data_key;
            m_valid = 1'b1;
         end else begin
            m_instr = NOP;
            m_valid = 1'b0;
         end
      end
      chk("valid_ID", 32'(valid_id), 32'(m_valid));
      chk("PC_ID", pc_id, m_pc);
      chk("instr_ID", instr_id, m_instr);
   end

   task automatic redirect_check(input logic st, input logic [31:0] tgt, input logic [31:0] exp);
      @(negedge clk);
      drive(st, 1'b1, tgt);
      chk("redir_no_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      chk("redir_bubble", 32'(valid_id), 32'd0);
      drive(1'b0, 1'b0, 32'h0);
      chk("redir_req", 32'(imem_req), 32'd1);
      chk("redir_addr", imem_addr, exp);
      for (int k = 2; k < 4; k++) begin
         @(negedge clk);
         chk("redir_bubble", 32'(valid_id), 32'd0);
         drive(1'b0, 1'b0, 32'h0);
      end
      @(negedge clk);
      chk("redir_valid", 32'(valid_id), 32'd1);
      chk("redir_pc", pc_id, exp);
      chk("redir_instr", instr_id, exp ^ data_key);
      drive(1'b0, 1'b0, 32'h0);
      run(4);
   endtask

   initial begin
      rst_ni        = 1'b0;
      stall         = 1'b0;
      branch        = 1'b0;
      branch_target = 32'h0;
      imem_gnt      = 1'b0;
      imem_rvalid   = 1'b0;
      imem_rdata    = 32'h0;
      data_key      = 32'h0;
      gnt_pct       = 100;
      lat_min       = 1;
      lat_max       = 1;
      cyc           = 0;

      run(3);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(valid_id), 32'd0);
      chk("rst_pc", pc_id, 32'h0);
      chk("rst_instr", instr_id, NOP);

      // Zero-wait memory returning rdata == address
      @(negedge clk);
      rst_ni = 1'b1;
      drive(1'b0, 1'b0, 32'h0);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, RESET_PC);
      for (int n = 1; n < 20; n++) begin
         @(negedge clk);
         if (n >= 3) begin
            chk("zw_valid", 32'(valid_id), 32'd1);
            chk("zw_pc", pc_id, 32'(4 * (n - 3)));
            chk("zw_instr", instr_id, 32'(4 * (n - 3)));
         end
         drive(1'b0, 1'b0, 32'h0);
      end

      // Three-cycle stall mid-stream
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0);
      chk("stall_req_low", 32'(imem_req), 32'd0);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0);
      run(6);

      // Redirects: plain, coincident with stall and a response, and across the wrap
      redirect_check(1'b0, 32'h0000_0100, 32'h0000_0100);
      redirect_check(1'b1, 32'h0000_0203, 32'h0000_0200);
      redirect_check(1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
      run(4);

      // Three-cycle latency memory, then a redirect with two fetches pending
      lat_min = 3;
      lat_max = 3;
      run(20);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h0000_0100);
      run(15);

      // Asynchronous reset mid-cycle with fetches in flight
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_rst_req", 32'(imem_req), 32'd0);
      chk("async_rst_valid", 32'(valid_id), 32'd0);
      chk("async_rst_pc", pc_id, 32'h0);
      chk("async_rst_instr", instr_id, NOP);
      cr_rst = 1'b1;
      mq.delete();
      run(2);
      data_key = $urandom;
      @(negedge clk);
      rst_ni = 1'b1;
      drive(1'b0, 1'b0, 32'h0);
      chk("restart_req", 32'(imem_req), 32'd1);
      chk("restart_addr", imem_addr, RESET_PC);
      run(10);

      // Randomized traffic under several memory behaviours
      for (int cfg = 0; cfg < 3; cfg++) begin
         gnt_pct = (cfg == 0) ? 100 : ((cfg == 1) ? 70 : 40);
         lat_min = (cfg == 2) ? 2 : 1;
         lat_max = (cfg == 0) ? 1 : ((cfg == 1) ? 3 : 5);
         repeat (1500) begin
            @(negedge clk);
            drive(($urandom_range(99) < 25), ($urandom_range(99) < 6), $urandom);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
